// File: rtl/aes_gf_pkg.sv
// ---------------------------------------------------------------------------
// aes_gf_pkg
// GF(2^8) helpers and MixColumns coefficient tables shared by the byte-serial
// forward and inverse MixColumns stages.
//   byte_t       : 8-bit state byte
//   row_t        : row position within a column (ROW0..ROW3)
//   AES_POLY     : reduction constant for xtime
//   INV_MC_COEF  : InvMixColumns matrix, [row][input row]
//   FWD_MC_COEF  : forward MixColumns matrix, [row][input row]
// ---------------------------------------------------------------------------
package aes_gf_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        ROW0,
        ROW1,
        ROW2,
        ROW3
    } row_t;

    localparam byte_t AES_POLY = 8'h1b;

    localparam byte_t INV_MC_COEF [4][4] = '{
        '{8'h0e, 8'h0b, 8'h0d, 8'h09},
        '{8'h09, 8'h0e, 8'h0b, 8'h0d},
        '{8'h0d, 8'h09, 8'h0e, 8'h0b},
        '{8'h0b, 8'h0d, 8'h09, 8'h0e}
    };

    localparam byte_t FWD_MC_COEF [4][4] = '{
        '{8'h02, 8'h03, 8'h01, 8'h01},
        '{8'h01, 8'h02, 8'h03, 8'h01},
        '{8'h01, 8'h01, 8'h02, 8'h03},
        '{8'h03, 8'h01, 8'h01, 8'h02}
    };

    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic byte_t gf_mul9(input byte_t a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic byte_t gf_mul11(input byte_t a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic byte_t gf_mul13(input byte_t a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic byte_t gf_mul14(input byte_t a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

    // Constant-coefficient multiply; the table coefficients take the short
    // xtime chains, anything else falls back to shift-and-add.
    function automatic byte_t gf_mul(input byte_t a, input byte_t c);
        byte_t p;
        byte_t s;
        case (c)
            8'h01:   p = a;
            8'h02:   p = xtime(a);
            8'h03:   p = xtime(a) ^ a;
            8'h09:   p = gf_mul9(a);
            8'h0b:   p = gf_mul11(a);
            8'h0d:   p = gf_mul13(a);
            8'h0e:   p = gf_mul14(a);
            default: begin
                p = '0;
                s = a;
                for (int unsigned i = 0; i < 8; i++) begin
                    if (c[i]) p = p ^ s;
                    s = xtime(s);
                end
            end
        endcase
        return p;
    endfunction

endpackage

// File: rtl/inv_mc_byte_mul.sv
// ---------------------------------------------------------------------------
// inv_mc_byte_mul
// Combinational column-slice multiplier: for input byte at row k, produces
// the four partial products M[r][k]*in_byte, r = 0..3.
// FORWARD selects the forward MixColumns matrix instead of the inverse one.
//   in_byte : state byte
//   k       : row index of in_byte within its column
//   prod    : prod[r] = M[r][k] * in_byte
// ---------------------------------------------------------------------------
module inv_mc_byte_mul
    import aes_gf_pkg::*;
#(
    parameter bit FORWARD = 1'b0
) (
    input  logic [7:0]       in_byte,
    input  row_t             k,
    output logic [3:0][7:0]  prod
);

    always_comb begin
        prod = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            prod[r] = gf_mul(in_byte, FORWARD ? FWD_MC_COEF[r][k] : INV_MC_COEF[r][k]);
        end
    end

endmodule

// File: rtl/inv_mix_columns_serial.sv
// ---------------------------------------------------------------------------
// inv_mix_columns_serial
// Byte-serial AES InvMixColumns. Takes one state byte per cycle (rows 0..3 of
// a column), accumulates GF(2^8) partial products, and presents each finished
// column in parallel behind a valid/ready handshake.
//   clock, reset          : clock, synchronous active-high reset
//   in_valid/in_byte      : input byte stream, row order 0,1,2,3
//   in_ready              : byte accepted when in_valid && in_ready
//   out_valid/out_ready   : column handshake
//   out_byte_0..3         : finished column, rows 0..3
//   out_last              : column is the last of the AES state
// Optional macro INV_MC_BYPASS_EN adds input `bypass` (sampled on row 0,
// held for the column) which passes the column through unmixed.
// ---------------------------------------------------------------------------
module inv_mix_columns_serial
    import aes_gf_pkg::*;
#(
    parameter int unsigned COLS_PER_STATE = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
`ifdef INV_MC_BYPASS_EN
    input  logic       bypass,
`endif
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte_0,
    output logic [7:0] out_byte_1,
    output logic [7:0] out_byte_2,
    output logic [7:0] out_byte_3,
    output logic       out_last
);

    localparam int unsigned COL_W = (COLS_PER_STATE > 1) ? $clog2(COLS_PER_STATE) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS_PER_STATE - 1);

    row_t             row_q;
    logic [3:0][7:0]  acc_q;
    logic [3:0][7:0]  out_q;
    logic [COL_W-1:0] col_q;
    logic             out_valid_q;
    logic             out_last_q;

    logic [3:0][7:0]  prod;
    logic [3:0][7:0]  term;
    logic [3:0][7:0]  acc_next;
    logic             accept;
    logic             col_done;

    assign in_ready = !(out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;
    assign col_done = accept && (row_q == ROW3);

    inv_mc_byte_mul #(.FORWARD(1'b0)) u_mul (
        .in_byte (in_byte),
        .k       (row_q),
        .prod    (prod)
    );

`ifdef INV_MC_BYPASS_EN
    logic bypass_q;
    logic bypass_eff;

    // Row 0 uses the live pin so the column's first byte already sees it.
    assign bypass_eff = (row_q == ROW0) ? bypass : bypass_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            bypass_q <= 1'b0;
        end else if (accept && (row_q == ROW0)) begin
            bypass_q <= bypass;
        end
    end

    always_comb begin
        term = prod;
        if (bypass_eff) begin
            term = '0;
            term[row_q] = in_byte;
        end
    end
`else
    assign term = prod;
`endif

    // Row 0 overwrites the accumulator, so columns need no clear cycle.
    always_comb begin
        acc_next = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            acc_next[r] = ((row_q == ROW0) ? 8'h00 : acc_q[r]) ^ term[r];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            row_q       <= ROW0;
            acc_q       <= '0;
            out_q       <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            if (accept) begin
                acc_q <= acc_next;
                row_q <= row_t'(row_q + 2'd1);
            end
            if (col_done) begin
                out_q       <= acc_next;
                out_valid_q <= 1'b1;
                out_last_q  <= (col_q == COL_LAST);
                col_q       <= (col_q == COL_LAST) ? '0 : col_q + 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_byte_0 = out_q[0];
    assign out_byte_1 = out_q[1];
    assign out_byte_2 = out_q[2];
    assign out_byte_3 = out_q[3];

endmodule

// File: tb/tb_inv_mix_columns_serial.sv
// ---------------------------------------------------------------------------
// tb_inv_mix_columns_serial
// Directed and randomized stimulus against a matrix-multiply reference model.
// Expected columns are queued when the bench sees a byte accepted and popped
// when the output handshake completes.
// ---------------------------------------------------------------------------
module tb_inv_mix_columns_serial;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_byte_0, out_byte_1, out_byte_2, out_byte_3;
    logic       out_last;
    logic       bypass_s = 1'b0;

    int unsigned checks = 0;
    int unsigned passes = 0;

    inv_mix_columns_serial #(.COLS_PER_STATE(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
`ifdef INV_MC_BYPASS_EN
        .bypass     (bypass_s),
`endif
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte_0 (out_byte_0),
        .out_byte_1 (out_byte_1),
        .out_byte_2 (out_byte_2),
        .out_byte_3 (out_byte_3),
        .out_last   (out_last)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    logic [7:0]  m_inv [4][4] = '{
        '{8'h0e, 8'h0b, 8'h0d, 8'h09},
        '{8'h09, 8'h0e, 8'h0b, 8'h0d},
        '{8'h0d, 8'h09, 8'h0e, 8'h0b},
        '{8'h0b, 8'h0d, 8'h09, 8'h0e}
    };
    logic [7:0]  partial [$];
    logic        part_bypass;
    int unsigned col_m = 0;
    logic [32:0] exp_q [$];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        while (y != 0) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic model_byte(input logic [7:0] b, input logic byp);
        logic [31:0] col;
        logic [7:0]  o;
        if (partial.size() == 0) part_bypass = byp;
        partial.push_back(b);
        if (partial.size() == 4) begin
            for (int r = 0; r < 4; r++) begin
                o = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    if (part_bypass) o = o ^ ((r == k) ? partial[k] : 8'h00);
                    else             o = o ^ gmul(m_inv[r][k], partial[k]);
                end
                col[31-8*r -: 8] = o;
            end
            exp_q.push_back({col, col_m == 3});
            col_m = (col_m + 1) % 4;
            partial.delete();
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // ---------------- output monitor ----------------
    logic        held_prev = 1'b0;
    logic [32:0] prev_out;

    always @(negedge clock) begin
        logic [32:0] cur;
        #4;
        cur = {out_byte_0, out_byte_1, out_byte_2, out_byte_3, out_last};
        if (reset) begin
            held_prev = 1'b0;
        end else begin
            if (held_prev) check("held_stable", 64'(cur), 64'(prev_out));
            if (out_valid && !out_ready) check("in_ready_stall", 64'(in_ready), 64'(1'b0));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_column", 64'(cur), 64'h1_dead_beef);
                else                   check("column", 64'(cur), 64'(exp_q.pop_front()));
            end
            held_prev = out_valid && !out_ready;
            prev_out  = cur;
        end
    end

    // ---------------- driver ----------------
    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        bit got = 1'b0;
        repeat (gap) begin
            @(negedge clock);
            in_valid = 1'b0;
        end
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_byte  = b;
            #4;
            if (in_ready) begin
                model_byte(b, bypass_s);
                got = 1'b1;
            end
        end
        if (!got) check("accept_timeout", 64'(got), 64'(1'b1));
    endtask

    task automatic send_col(input logic [31:0] w, input int unsigned maxgap);
        for (int i = 0; i < 4; i++)
            send_byte(w[31-8*i -: 8], (maxgap == 0) ? 0 : $urandom_range(0, maxgap));
    endtask

    task automatic idle();
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clock);
            #2;
            if (exp_q.size() == 0 && !out_valid) done = 1'b1;
        end
        if (!done) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] vec [4] = '{32'h8e4da1bc, 32'hd5d5d7d6, 32'h01010101, 32'hc6c6c6c6};
    bit rand_done;

    initial begin
        // reset state
        repeat (3) @(negedge clock);
        #4;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_bytes", 64'({out_byte_0, out_byte_1, out_byte_2, out_byte_3}), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #4;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // first column back to back, with latency check
        send_col(32'h8e4da1bc, 0);
        check("pre_latency_valid", 64'(out_valid), 64'd0);
        idle();
        #1;
        check("latency_valid", 64'(out_valid), 64'd1);
        check("known_vec0", 64'({out_byte_0, out_byte_1, out_byte_2, out_byte_3}), 64'hdb135345);
        send_col(vec[1], 0);
        send_col(vec[2], 0);
        send_col(vec[3], 0);
        idle();
        wait_drain();

        // one full state with input gaps
        for (int c = 0; c < 4; c++) send_col(vec[c], 3);
        idle();
        wait_drain();

        // output stall: hold out_ready low for 5 cycles after column completes
        out_ready = 1'b0;
        send_col(vec[0], 0);
        fork
            send_col(vec[1], 0);
            begin
                for (int i = 0; i < 100 && !out_valid; i++) @(negedge clock);
                repeat (5) @(negedge clock);
                out_ready = 1'b1;
            end
        join
        idle();
        wait_drain();

        // reset mid-column; counters must restart
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        @(negedge clock);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        reset    = 1'b0;
        partial.delete();
        col_m = 0;
        send_col(32'h4d7ebdf8, 0);
        idle();
        #1;
        check("post_reset_vec", 64'({out_byte_0, out_byte_1, out_byte_2, out_byte_3, out_last}),
              64'({32'h2d26314c, 1'b0}));
        for (int c = 0; c < 3; c++) send_col($urandom, 1);
        idle();
        wait_drain();

        // randomized columns with random backpressure
        rand_done = 1'b0;
        fork
            begin
                for (int c = 0; c < 10; c++) send_col($urandom, 2);
                idle();
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clock);
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        @(negedge clock);
        out_ready = 1'b1;
        wait_drain();

`ifdef INV_MC_BYPASS_EN
        bypass_s = 1'b1;
        send_col(32'h11223344, 0);
        bypass_s = 1'b0;
        idle();
        #1;
        check("bypass_latency", 64'(out_valid), 64'd1);
        check("bypass_vec", 64'({out_byte_0, out_byte_1, out_byte_2, out_byte_3}), 64'h11223344);
        send_col(32'h8e4da1bc, 0);
        idle();
        wait_drain();
`endif

        #4;
        check("final_idle", 64'(out_valid), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
